snake_key_ctrl: RTL and testbench

Keyboard command controller between the UART receiver's RX FIFO and the snake game logic. It drains the FIFO one byte at a time through the `rd_uart` pop strobe and decodes WASD, space and `r` bytes into commands. Direction changes are buffered in a 2-entry queue, with reversals rejected, and applied one per game tick. It also produces the pause state and a restart pulse.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/dir_queue.sv | 56 +++++
 rtl/snake_key_ctrl.sv | 112 +++++++++++
 tb/tb_snake_key_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared directions, FSM states and default key codes for snake_key_ctrl
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SETTLE  = 2'd2
    } state_t;

    localparam logic [7:0] DEF_KEY_UP      = 8'h77;
    localparam logic [7:0] DEF_KEY_LEFT    = 8'h61;
    localparam logic [7:0] DEF_KEY_DOWN    = 8'h73;
    localparam logic [7:0] DEF_KEY_RIGHT   = 8'h64;
    localparam logic [7:0] DEF_KEY_PAUSE   = 8'h20;
    localparam logic [7:0] DEF_KEY_RESTART = 8'h72;

    // Letter match that ignores ASCII case (bit 5)
    function automatic logic key_match(input logic [7:0] key, input logic [7:0] code);
        return (key & 8'hDF) == (code & 8'hDF);
    endfunction

endpackage

// File: rtl/dir_queue.sv
// rtl/dir_queue.sv - 2-entry FIFO of pending snake directions
module dir_queue (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic [1:0] count
);

    logic [1:0] slot0;
    logic [1:0] slot1;
    logic       do_pop;

    assign head   = slot0;
    assign tail   = (count == 2'd2) ? slot1 : slot0;
    assign do_pop = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot0 <= 2'b00;
            slot1 <= 2'b00;
            count <= 2'd0;
        end else begin
            unique case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= din;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot1 <= din;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Pop frees a slot, so a push is accepted even when full
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/snake_key_ctrl.sv
// rtl/snake_key_ctrl.sv - UART key decoder producing snake direction, pause and restart
module snake_key_ctrl
    import snake_pkg::*;
#(
    parameter logic [7:0] KEY_UP      = DEF_KEY_UP,
    parameter logic [7:0] KEY_LEFT    = DEF_KEY_LEFT,
    parameter logic [7:0] KEY_DOWN    = DEF_KEY_DOWN,
    parameter logic [7:0] KEY_RIGHT   = DEF_KEY_RIGHT,
    parameter logic [7:0] KEY_PAUSE   = DEF_KEY_PAUSE,
    parameter logic [7:0] KEY_RESTART = DEF_KEY_RESTART,
    parameter logic [1:0] INIT_DIR    = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       game_tick,
    output logic [1:0] dir,
    output logic       paused,
    output logic       restart,
    output logic [7:0] last_key
);

    state_t     state;
    logic [7:0] key_reg;
    logic       capture;
    logic       is_dir_key;
    logic [1:0] key_dir;
    logic [1:0] ref_dir;
    logic       do_restart;
    logic       do_pause;
    logic       q_push;
    logic       q_pop;
    logic [1:0] q_head;
    logic [1:0] q_tail;
    logic [1:0] q_count;

    // Pop is combinational so the FWFT head is consumed in the cycle it is seen
    assign rd_uart = (state == ST_IDLE) && !rx_empty && !rst;
    assign capture = (state == ST_CAPTURE);

    always_comb begin
        is_dir_key = 1'b1;
        key_dir    = DIR_UP;
        if (key_match(key_reg, KEY_UP))
            key_dir = DIR_UP;
        else if (key_match(key_reg, KEY_LEFT))
            key_dir = DIR_LEFT;
        else if (key_match(key_reg, KEY_DOWN))
            key_dir = DIR_DOWN;
        else if (key_match(key_reg, KEY_RIGHT))
            key_dir = DIR_RIGHT;
        else
            is_dir_key = 1'b0;
    end

    assign do_restart = capture && key_match(key_reg, KEY_RESTART);
    assign do_pause   = capture && (key_reg == KEY_PAUSE);
    // Reversal check uses the pre-pop tail, falling back to the applied direction
    assign ref_dir    = (q_count != 2'd0) ? q_tail : dir;
    assign q_push     = capture && is_dir_key && (key_dir != ref_dir) &&
                        (key_dir != (ref_dir ^ 2'b10));
    assign q_pop      = game_tick && !paused && (q_count != 2'd0) && !do_restart;

    dir_queue u_dir_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (do_restart),
        .push  (q_push),
        .pop   (q_pop),
        .din   (key_dir),
        .head  (q_head),
        .tail  (q_tail),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            key_reg  <= 8'h00;
            last_key <= 8'h00;
            dir      <= INIT_DIR;
            paused   <= 1'b0;
            restart  <= 1'b0;
        end else begin
            restart <= do_restart;
            unique case (state)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        key_reg  <= r_data;
                        last_key <= r_data;
                        state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: state <= ST_SETTLE;
                ST_SETTLE:  state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
            if (do_restart) begin
                dir    <= INIT_DIR;
                paused <= 1'b0;
            end else begin
                if (q_pop)
                    dir <= q_head;
                if (do_pause)
                    paused <= !paused;
            end
        end
    end

endmodule

// File: tb/tb_snake_key_ctrl.sv
// tb/tb_snake_key_ctrl.sv - scoreboard bench for snake_key_ctrl
module tb_snake_key_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       game_tick;
    logic [1:0] dir;
    logic       paused;
    logic       restart;
    logic [7:0] last_key;

    snake_key_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .game_tick (game_tick),
        .dir       (dir),
        .paused    (paused),
        .restart   (restart),
        .last_key  (last_key)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pop_cyc = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] key_exp_q[$];
    logic [1:0] dir_exp_q[$];
    logic       paused_exp_q[$];
    bit         restart_exp_q[$];

    logic       pop_req = 1'b0;
    logic       prev_rd = 1'b0;
    logic       prev_restart = 1'b0;
    logic       prev_paused = 1'b0;
    logic [1:0] prev_dir = 2'b01;
    logic       tick_prev = 1'b0;
    logic       key_pending = 1'b0;
    logic [7:0] key_next = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // FIFO model: first-word-fall-through, popped one cycle after rd_uart is seen
    always @(posedge clk) begin
        #1;
        if (pop_req && fifo_q.size() > 0)
            void'(fifo_q.pop_front());
        rx_empty = (fifo_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo_q[0];
    end

    // Monitor: every observable output event is matched against the scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pop_req      = 1'b0;
            prev_rd      = 1'b0;
            prev_restart = 1'b0;
            prev_paused  = paused;
            prev_dir     = dir;
            tick_prev    = 1'b0;
            key_pending  = 1'b0;
        end else begin
            pop_req = rd_uart;
            if (key_pending) begin
                check("last_key", last_key, key_next);
                key_pending = 1'b0;
            end
            if (rd_uart) begin
                check("rd_uart_gap", prev_rd, 1'b0);
                check("rd_uart_empty", rx_empty, 1'b0);
                if (key_exp_q.size() == 0) begin
                    unexpected("rd_uart_pop");
                end else begin
                    key_next    = key_exp_q.pop_front();
                    key_pending = 1'b1;
                end
                last_pop_cyc = cyc;
            end
            if (restart) begin
                check("restart_width", prev_restart, 1'b0);
                check("restart_latency", cyc - last_pop_cyc, 2);
                if (restart_exp_q.size() == 0) unexpected("restart");
                else void'(restart_exp_q.pop_front());
            end
            if (paused !== prev_paused) begin
                check("paused_latency", cyc - last_pop_cyc, 2);
                if (paused_exp_q.size() == 0) unexpected("paused");
                else check("paused", paused, paused_exp_q.pop_front());
            end
            if (dir !== prev_dir) begin
                if (!restart) check("dir_tick_latency", tick_prev, 1'b1);
                if (dir_exp_q.size() == 0) unexpected("dir");
                else check("dir", dir, dir_exp_q.pop_front());
            end
            prev_rd      = rd_uart;
            prev_restart = restart;
            prev_paused  = paused;
            prev_dir     = dir;
            tick_prev    = game_tick;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        key_exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #2 game_tick = 1'b1;
        @(posedge clk);
        #2 game_tick = 1'b0;
        step(2);
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_q.size() != 0 && n < 60) begin
            step(1);
            n++;
        end
        if (fifo_q.size() != 0) unexpected("fifo_drain_timeout");
        step(6);
    endtask

    // Send a byte and pulse game_tick in the cycle its decode happens
    task automatic send_with_tick(input logic [7:0] b);
        int n = 0;
        send(b);
        @(negedge clk);
        while (!rd_uart && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!rd_uart) unexpected("pop_timeout");
        @(posedge clk);
        #2 game_tick = 1'b1;
        @(posedge clk);
        #2 game_tick = 1'b0;
        step(4);
    endtask

    initial begin
        rst       = 1'b1;
        game_tick = 1'b0;
        rx_empty  = 1'b1;
        r_data    = 8'h00;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_dir", dir, 2'b01);
        check("reset_paused", paused, 1'b0);
        check("reset_restart", restart, 1'b0);
        check("reset_last_key", last_key, 8'h00);
        check("reset_rd_uart", rd_uart, 1'b0);
        step(1);

        send(8'h77); drain();
        dir_exp_q.push_back(2'b00); tick();

        send(8'h64); drain();
        dir_exp_q.push_back(2'b01); tick();
        send(8'h61); send(8'h77); drain();
        dir_exp_q.push_back(2'b00); tick();

        send(8'h64); drain();
        dir_exp_q.push_back(2'b01); tick();
        send(8'h77); send(8'h61); send(8'h73); drain();
        dir_exp_q.push_back(2'b00); tick();
        dir_exp_q.push_back(2'b11); tick();
        tick();

        send(8'h73); drain();
        paused_exp_q.push_back(1'b1); send(8'h20); drain();
        tick(); tick(); tick();
        paused_exp_q.push_back(1'b0); send(8'h20); drain();
        dir_exp_q.push_back(2'b10); tick();

        send(8'h61); drain();
        paused_exp_q.push_back(1'b1); send(8'h20); drain();
        restart_exp_q.push_back(1'b1);
        dir_exp_q.push_back(2'b01);
        paused_exp_q.push_back(1'b0);
        send(8'h72); drain();
        tick();

        send(8'h77); drain();
        restart_exp_q.push_back(1'b1);
        send_with_tick(8'h72);
        tick();

        send(8'h77); drain();
        dir_exp_q.push_back(2'b00);
        send_with_tick(8'h73);
        tick();

        send(8'h61); send(8'h73); drain();
        dir_exp_q.push_back(2'b11);
        send_with_tick(8'h64);
        dir_exp_q.push_back(2'b10); tick();
        dir_exp_q.push_back(2'b01); tick();
        tick();

        send(8'h77);
        begin
            int n = 0;
            @(negedge clk);
            while (!rd_uart && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (!rd_uart) unexpected("pop_timeout_rst");
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dir", dir, 2'b01);
        check("rst_paused", paused, 1'b0);
        check("rst_restart", restart, 1'b0);
        check("rst_last_key", last_key, 8'h00);
        check("rst_rd_uart", rd_uart, 1'b0);
        step(1);
        send(8'h78); drain();
        tick();
        step(4);

        check("missing_key_pops", key_exp_q.size(), 0);
        check("missing_dir_events", dir_exp_q.size(), 0);
        check("missing_paused_events", paused_exp_q.size(), 0);
        check("missing_restart_events", restart_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
